// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int WORD_SIZE_DEFAULT = 16;

  // Grant value doubles as the arbiter state encoding.
  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_INSTR = 2'd1,
    GNT_DATA  = 2'd2
  } grant_t;

endpackage

// File: rtl/watchdog_counter.sv
// Per-transaction stall counter. terminal_o pulses combinationally on the
// LIMIT-th counted cycle; a LIMIT of 0 disables the watchdog entirely.
module watchdog_counter #(
  parameter int LIMIT = 64
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear_i,
  input  logic count_en_i,
  output logic terminal_o
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  // count_q holds the stalls seen before this cycle, so the LIMIT-th stall
  // is the one arriving while count_q sits at LIMIT-1.
  localparam logic [CNT_W-1:0] LAST = (LIMIT > 0) ? CNT_W'(LIMIT - 1) : '0;

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear has priority over increment.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal_o = (LIMIT != 0) && count_en_i && (count_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, variable-latency memory bus between the
// instruction-fetch port and the data port. Data wins ties; on completion the
// bus is handed straight to the other port if it is waiting.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_SIZE      = WORD_SIZE_DEFAULT,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [WORD_SIZE-1:0] IAddr,
  input  logic                 IRead,
  output logic [WORD_SIZE-1:0] IRdData,
  output logic                 IWaitreq,
  input  logic [WORD_SIZE-1:0] DAddr,
  input  logic [WORD_SIZE-1:0] DWrData,
  input  logic                 DRead,
  input  logic                 DWrite,
  output logic [WORD_SIZE-1:0] DRdData,
  output logic                 DWaitreq,
  output logic [WORD_SIZE-1:0] MemAddr,
  output logic [WORD_SIZE-1:0] MemWrData,
  output logic                 MemRead,
  output logic                 MemWrite,
  input  logic [WORD_SIZE-1:0] MemRdData,
  input  logic                 MemWaitreq,
  output logic [1:0]           Grant,
  output logic                 ErrProtocol,
  output logic                 ErrTimeout
);

  grant_t state_q, state_d;
  logic   err_proto_q, err_proto_d;
  logic   err_timeout_q, err_timeout_d;
  logic   d_req;
  logic   granted_req;
  logic   wd_count;
  logic   wd_clear;
  logic   wd_fire;
  logic   set_proto;
  logic   set_timeout;

  assign d_req = DRead | DWrite;

  // The granted port's live request is also its memory strobe.
  assign granted_req = (state_q == GNT_DATA)  ? d_req :
                       (state_q == GNT_INSTR) ? IRead : 1'b0;

  assign wd_count = ~Reset & granted_req & MemWaitreq;
  // Any state change starts a fresh tenure for the watchdog.
  assign wd_clear = Reset | (state_d != state_q);

  watchdog_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .Clock      (Clock),
    .Reset      (Reset),
    .clear_i    (wd_clear),
    .count_en_i (wd_count),
    .terminal_o (wd_fire)
  );

  // Next-state selection and the memory-bus / requester-side mux.
  always_comb begin
    state_d     = state_q;
    MemAddr     = '0;
    MemWrData   = '0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRdData     = '0;
    DRdData     = '0;
    IWaitreq    = IRead;
    DWaitreq    = d_req;
    set_proto   = 1'b0;
    set_timeout = 1'b0;

    if (Reset) begin
      state_d = GNT_NONE;
    end else begin
      unique case (state_q)
        GNT_NONE: begin
          if (d_req) begin
            state_d = GNT_DATA;
          end else if (IRead) begin
            state_d = GNT_INSTR;
          end
        end

        GNT_INSTR: begin
          MemAddr = IAddr;
          if (!IRead) begin
            // Request withdrawn mid-transaction: abort.
            set_proto = 1'b1;
            state_d   = GNT_NONE;
          end else if (wd_fire) begin
            IWaitreq    = 1'b0;
            set_timeout = 1'b1;
            state_d     = GNT_NONE;
          end else begin
            MemRead = 1'b1;
            if (!MemWaitreq) begin
              IWaitreq = 1'b0;
              IRdData  = MemRdData;
              state_d  = d_req ? GNT_DATA : GNT_NONE;
            end
          end
        end

        GNT_DATA: begin
          MemAddr   = DAddr;
          MemWrData = DWrData;
          if (!d_req) begin
            set_proto = 1'b1;
            state_d   = GNT_NONE;
          end else begin
            // Read and write together is illegal; the write wins.
            if (DRead && DWrite) begin
              set_proto = 1'b1;
            end
            if (wd_fire) begin
              DWaitreq    = 1'b0;
              set_timeout = 1'b1;
              state_d     = GNT_NONE;
            end else begin
              MemWrite = DWrite;
              MemRead  = DRead & ~DWrite;
              if (!MemWaitreq) begin
                DWaitreq = 1'b0;
                DRdData  = MemRdData;
                state_d  = IRead ? GNT_INSTR : GNT_NONE;
              end
            end
          end
        end

        default: state_d = GNT_NONE;
      endcase
    end
  end

  // Sticky error flags: set by any violation, cleared only by reset.
  always_comb begin
    err_proto_d   = err_proto_q | set_proto;
    err_timeout_d = err_timeout_q | set_timeout;
  end

  // State and flag registers, synchronous active-high reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= GNT_NONE;
      err_proto_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      err_proto_q   <= err_proto_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Grant reads as none for the whole reset cycle, even mid-transaction.
  assign Grant       = Reset ? 2'(GNT_NONE) : 2'(state_q);
  assign ErrProtocol = err_proto_q;
  assign ErrTimeout  = err_timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, every cycle compared against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int W  = 16;
  localparam int TO = 4;

  logic         Clock = 1'b0;
  logic         Reset;
  logic [W-1:0] IAddr, DAddr, DWrData, MemRdData;
  logic         IRead, DRead, DWrite, MemWaitreq;
  logic [W-1:0] IRdData, DRdData, MemAddr, MemWrData;
  logic         IWaitreq, DWaitreq, MemRead, MemWrite;
  logic [1:0]   Grant;
  logic         ErrProtocol, ErrTimeout;

  always #5 Clock = ~Clock;

  mem_port_arbiter #(.WORD_SIZE(W), .TIMEOUT_CYCLES(TO)) dut (
    .Clock(Clock), .Reset(Reset),
    .IAddr(IAddr), .IRead(IRead), .IRdData(IRdData), .IWaitreq(IWaitreq),
    .DAddr(DAddr), .DWrData(DWrData), .DRead(DRead), .DWrite(DWrite),
    .DRdData(DRdData), .DWaitreq(DWaitreq),
    .MemAddr(MemAddr), .MemWrData(MemWrData), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemRdData(MemRdData), .MemWaitreq(MemWaitreq),
    .Grant(Grant), .ErrProtocol(ErrProtocol), .ErrTimeout(ErrTimeout)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: who owns the bus (0 none, 1 instr, 2 data), stalls seen in
  // the current tenure, and the sticky flags.
  int m_owner = 0;
  int m_stall = 0;
  bit m_perr  = 1'b0;
  bit m_terr  = 1'b0;
  bit i_done, d_done;

  // Evaluate one cycle mid-period against the model, then advance on the edge.
  task automatic eval_cycle();
    logic [W-1:0] e_addr, e_wd, e_ird, e_drd;
    bit e_rd, e_wr, e_iw, e_dw, dreq, req, other, np, nt;
    int nxt, nstall, e_gnt;
    #4;
    dreq   = DRead | DWrite;
    e_addr = '0; e_wd = '0; e_ird = '0; e_drd = '0;
    e_rd = 0; e_wr = 0; e_iw = IRead; e_dw = dreq;
    nxt = m_owner; nstall = m_stall; np = m_perr; nt = m_terr;
    e_gnt = Reset ? 0 : m_owner;
    if (Reset) begin
      nxt = 0; nstall = 0; np = 0; nt = 0;
    end else if (m_owner == 0) begin
      nxt = dreq ? 2 : (IRead ? 1 : 0);
    end else begin
      req   = (m_owner == 2) ? dreq : IRead;
      other = (m_owner == 2) ? IRead : dreq;
      if (!req) begin
        np = 1; nxt = 0;
      end else begin
        if (m_owner == 2) begin
          e_addr = DAddr; e_wd = DWrData;
          e_wr = DWrite; e_rd = DRead && !DWrite;
          if (DRead && DWrite) np = 1;
        end else begin
          e_addr = IAddr; e_rd = 1;
        end
        if (MemWaitreq && TO != 0 && m_stall + 1 == TO) begin
          e_rd = 0; e_wr = 0; nt = 1; nxt = 0;
          if (m_owner == 2) e_dw = 0; else e_iw = 0;
        end else if (MemWaitreq) begin
          nstall = m_stall + 1;
        end else begin
          if (m_owner == 2) begin e_dw = 0; e_drd = MemRdData; end
          else begin e_iw = 0; e_ird = MemRdData; end
          nxt = other ? 3 - m_owner : 0;
        end
      end
    end
    if (nxt != m_owner) nstall = 0;

    check("grant",     32'(Grant),       32'(e_gnt));
    check("mem_read",  32'(MemRead),     32'(e_rd));
    check("mem_write", 32'(MemWrite),    32'(e_wr));
    check("i_waitreq", 32'(IWaitreq),    32'(e_iw));
    check("d_waitreq", 32'(DWaitreq),    32'(e_dw));
    check("i_rddata",  32'(IRdData),     32'(e_ird));
    check("d_rddata",  32'(DRdData),     32'(e_drd));
    check("err_proto", 32'(ErrProtocol), 32'(m_perr));
    check("err_tmo",   32'(ErrTimeout),  32'(m_terr));
    if (e_rd || e_wr) check("mem_addr", 32'(MemAddr), 32'(e_addr));
    if (e_wr) check("mem_wrdata", 32'(MemWrData), 32'(e_wd));
    if (Reset || m_owner == 0) begin
      check("idle_addr",   32'(MemAddr),   32'd0);
      check("idle_wrdata", 32'(MemWrData), 32'd0);
    end

    i_done = IRead && !e_iw;
    d_done = dreq && !e_dw;
    @(posedge Clock);
    m_owner = nxt; m_stall = nstall; m_perr = np; m_terr = nt;
    #1;
  endtask

  task automatic drive(input bit rst, input bit ir, input logic [W-1:0] ia,
                       input bit dr, input bit dw, input logic [W-1:0] da,
                       input logic [W-1:0] wd, input bit mw, input logic [W-1:0] mrd);
    Reset = rst; IRead = ir; IAddr = ia; DRead = dr; DWrite = dw;
    DAddr = da; DWrData = wd; MemWaitreq = mw; MemRdData = mrd;
    eval_cycle();
  endtask

  // Random requesters obey the hold-while-waiting rule, with rare aborts.
  task automatic next_random_inputs();
    int r;
    if (IRead && !i_done) begin
      if ($urandom % 50 == 0) IRead = 1'b0;
    end else begin
      IRead = ($urandom % 3 != 0);
      IAddr = W'($urandom);
    end
    if ((DRead || DWrite) && !d_done) begin
      if ($urandom % 50 == 0) begin DRead = 1'b0; DWrite = 1'b0; end
    end else begin
      r = int'($urandom % 20);
      DRead   = (r >= 7 && r <= 12) || r == 19;
      DWrite  = (r >= 13);
      DAddr   = W'($urandom);
      DWrData = W'($urandom);
    end
    MemRdData = W'($urandom);
    Reset     = ($urandom % 200 == 0);
  endtask

  int stuck;

  initial begin
    Reset = 1'b1; IRead = 0; DRead = 0; DWrite = 0; IAddr = '0; DAddr = '0;
    DWrData = '0; MemWaitreq = 0; MemRdData = '0;
    repeat (2) @(posedge Clock);
    #1;
    drive(1, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0);

    // Instruction read, zero wait.
    drive(0, 1, 16'h0010, 0, 0, 16'h0, 16'h0, 0, 16'hA5A5);
    drive(0, 1, 16'h0010, 0, 0, 16'h0, 16'h0, 0, 16'hA5A5);
    drive(0, 0, 16'h0010, 0, 0, 16'h0, 16'h0, 0, 16'hA5A5);

    // Simultaneous requests: data write first, then instruction with no gap.
    drive(0, 1, 16'h0020, 0, 1, 16'h0100, 16'h1234, 0, 16'h5A5A);
    drive(0, 1, 16'h0020, 0, 1, 16'h0100, 16'h1234, 0, 16'h5A5A);
    drive(0, 1, 16'h0020, 0, 0, 16'h0100, 16'h1234, 0, 16'h7777);
    drive(0, 0, 16'h0020, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);

    // Three-cycle memory stall on a data read.
    drive(0, 0, 16'h0, 1, 0, 16'h0200, 16'h0, 0, 16'h0);
    repeat (3) drive(0, 0, 16'h0, 1, 0, 16'h0200, 16'h0, 1, 16'h1111);
    drive(0, 0, 16'h0, 1, 0, 16'h0200, 16'h0, 0, 16'hBEEF);
    drive(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0);

    // Watchdog: memory stuck, fires on the TO-th stalled cycle.
    drive(0, 0, 16'h0, 1, 0, 16'h0300, 16'h0, 1, 16'h2222);
    repeat (TO) drive(0, 0, 16'h0, 1, 0, 16'h0300, 16'h0, 1, 16'h2222);
    drive(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    drive(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    check("tmo_sticky", 32'(ErrTimeout), 32'd1);

    // Protocol violations: dropped request mid-stall, then read+write.
    drive(0, 0, 16'h0, 1, 0, 16'h0400, 16'h0, 1, 16'h0);
    drive(0, 0, 16'h0, 1, 0, 16'h0400, 16'h0, 1, 16'h0);
    drive(0, 0, 16'h0, 0, 0, 16'h0400, 16'h0, 1, 16'h0);
    drive(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    drive(0, 0, 16'h0, 1, 1, 16'h0500, 16'hCAFE, 0, 16'h0);
    drive(0, 0, 16'h0, 1, 1, 16'h0500, 16'hCAFE, 0, 16'h0);
    drive(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0);

    // Reset in the middle of a stalled data read, then normal service.
    drive(0, 0, 16'h0, 1, 0, 16'h0600, 16'h0, 1, 16'h3333);
    drive(0, 0, 16'h0, 1, 0, 16'h0600, 16'h0, 1, 16'h3333);
    drive(1, 0, 16'h0, 1, 0, 16'h0600, 16'h0, 1, 16'h3333);
    drive(0, 0, 16'h0, 1, 0, 16'h0600, 16'h0, 0, 16'h4444);
    drive(0, 0, 16'h0, 1, 0, 16'h0600, 16'h0, 0, 16'h4444);
    drive(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    check("flags_after_reset", 32'({ErrProtocol, ErrTimeout}), 32'd0);

    // Randomized traffic with occasional stuck-memory bursts and resets.
    stuck = 0;
    for (int n = 0; n < 3000; n++) begin
      next_random_inputs();
      if (stuck > 0) begin
        MemWaitreq = 1'b1;
        stuck--;
      end else if ($urandom % 30 == 0) begin
        MemWaitreq = 1'b1;
        stuck = 6;
      end else begin
        MemWaitreq = ($urandom % 4 == 0);
      end
      eval_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
